// File: rtl/riscv_defines.sv
// Shared RISC-V front-end definitions used by the fetch aligner.
package riscv_defines;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_HALF_WIDTH = 16;

  // Low two bits of the first parcel that mark a full-length instruction
  localparam logic [1:0] RISCV_OPC_32BIT = 2'b11;

  typedef enum logic {
    ALIGN_RUN,
    ALIGN_SKIP
  } align_state_e;
endpackage

// File: rtl/halfword_fifo.sv
// Four-entry halfword buffer. Entry 0 (hw0) is the oldest. One cycle can
// pop 0/1/2 and push 0/1/2 halfwords; pops are applied before pushes so
// a full-rate stream flows without bubbles. Entries at or above count are
// always zero, so hw1 reads as zero whenever fewer than two are held.
module halfword_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  push_cnt,
  input  logic [RISCV_WORD_WIDTH-1:0] push_data,
  input  logic [1:0]                  pop_cnt,
  output logic [RISCV_HALF_WIDTH-1:0] hw0,
  output logic [RISCV_HALF_WIDTH-1:0] hw1,
  output logic [2:0]                  count
);

  logic [DEPTH-1:0][RISCV_HALF_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][RISCV_HALF_WIDTH-1:0] mem_d;
  logic [2:0] count_q;
  logic [2:0] base;
  logic [2:0] count_d;

  // Shift out popped entries, then append pushed halfwords behind the survivors
  always_comb begin
    mem_d = mem_q >> {pop_cnt, 4'b0000};
    base  = count_q - {1'b0, pop_cnt};
    if (push_cnt != 2'd0) mem_d[base[1:0]] = push_data[15:0];
    if (push_cnt == 2'd2) mem_d[base[1:0] + 2'd1] = push_data[31:16];
    count_d = base + {1'b0, push_cnt};
  end

  // Storage and occupancy; flush discards everything
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign hw0   = mem_q[0];
  assign hw1   = mem_q[1];
  assign count = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns word-aligned fetch words into left-aligned
// instructions with their PC for the decompressor.
// Build option: define ALIGNER_RVC_EN to enable 16-bit (compressed)
// instruction handling; without it every entry is a 32-bit instruction.
module fetch_aligner
  import riscv_defines::*;
#(
  parameter logic [RISCV_WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int                          FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_i,
  input  logic [RISCV_WORD_WIDTH-1:0] redirect_pc_i,
  input  logic                        fetch_valid_i,
  output logic                        fetch_ready_o,
  input  logic [RISCV_WORD_WIDTH-1:0] fetch_data_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_WORD_WIDTH-1:0] instr_pc_o
);

  align_state_e                  state_q;
  logic [RISCV_WORD_WIDTH-1:0]   pc_q;
  logic [RISCV_HALF_WIDTH-1:0]   hw0;
  logic [RISCV_HALF_WIDTH-1:0]   hw1;
  logic [2:0]                    count;
  logic                          is_compressed;
  logic                          complete;
  logic                          word_acc;
  logic                          consume;
  logic [1:0]                    push_cnt;
  logic [1:0]                    pop_cnt;
  logic [RISCV_WORD_WIDTH-1:0]   push_data;
  logic                          unused_pc_bits;

  // Bit 0 of a redirect target is never meaningful
  assign unused_pc_bits = ^redirect_pc_i[1:0];

`ifdef ALIGNER_RVC_EN
  assign is_compressed = (hw0[1:0] != RISCV_OPC_32BIT);
`else
  assign is_compressed = 1'b0;
`endif

  assign complete      = is_compressed ? (count >= 3'd1) : (count >= 3'd2);
  assign fetch_ready_o = (count <= 3'(FIFO_DEPTH - 2)) | redirect_i;
  assign word_acc      = fetch_valid_i & fetch_ready_o;
  assign instr_valid_o = complete & ~redirect_i;
  assign instr_o       = {(count >= 3'd2) ? hw1 : {RISCV_HALF_WIDTH{1'b0}}, hw0};
  assign instr_pc_o    = pc_q;
  assign consume       = instr_valid_o & instr_ready_i;
  assign pop_cnt       = consume ? (is_compressed ? 2'd1 : 2'd2) : 2'd0;

  // A word arriving with a redirect is stale; after a halfword-aligned
  // redirect only the upper parcel of the first word belongs to the new path
  always_comb begin
    push_cnt  = 2'd0;
    push_data = fetch_data_i;
    if (word_acc && !redirect_i) begin
      if (state_q == ALIGN_SKIP) begin
        push_cnt  = 2'd1;
        push_data = {{RISCV_HALF_WIDTH{1'b0}}, fetch_data_i[31:16]};
      end else begin
        push_cnt = 2'd2;
      end
    end
  end

  halfword_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .push_cnt (push_cnt),
    .push_data(push_data),
    .pop_cnt  (pop_cnt),
    .hw0      (hw0),
    .hw1      (hw1),
    .count    (count)
  );

  // PC tracking and skip-low-half state; redirect overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIGN_RUN;
      pc_q    <= BOOT_ADDR;
    end else if (redirect_i) begin
`ifdef ALIGNER_RVC_EN
      pc_q    <= {redirect_pc_i[31:1], 1'b0};
      state_q <= redirect_pc_i[1] ? ALIGN_SKIP : ALIGN_RUN;
`else
      pc_q    <= {redirect_pc_i[31:2], 2'b00};
      state_q <= ALIGN_RUN;
`endif
    end else begin
      if (consume) pc_q <= pc_q + {29'd0, pop_cnt, 1'b0};
      if (word_acc && state_q == ALIGN_SKIP) state_q <= ALIGN_RUN;
    end
  end

endmodule
